// File: rtl/dromos_adder_pkg.sv
// dromos_adder_pkg: shared widths and types for the nibble-serial prefix adder
package dromos_adder_pkg;
  localparam int NIBBLE_W = 4;
  localparam int PG_W = 5;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} post_state_t;
  typedef logic [PG_W-1:0] pg_vec_t;
endpackage

// File: rtl/prefix_carry_4b.sv
// prefix_carry_4b: ripple-resolved carries and sum nibble for one propagate/generate beat
module prefix_carry_4b
  import dromos_adder_pkg::*;
(
  input  pg_vec_t               prop,
  input  pg_vec_t               gen,
  input  logic                  c_in,
  output logic [NIBBLE_W:1]     carry,
  output logic [NIBBLE_W-1:0]   sum
);
  logic [NIBBLE_W:0] c;
  logic unused_bit0;
  assign c[0] = c_in;
  assign unused_bit0 = prop[0] ^ gen[0];
  for (genvar i = 1; i <= NIBBLE_W; i++) begin : g_bit
    assign c[i]     = gen[i] | (prop[i] & c[i-1]);
    assign sum[i-1] = prop[i] ^ c[i-1];
  end
  assign carry = c[NIBBLE_W:1];
endmodule

// File: rtl/post_processing_4b_seq.sv
// post_processing_4b_seq: sequential nibble carry chain assembling a NIBBLES*4-bit sum
module post_processing_4b_seq
  import dromos_adder_pkg::*;
#(
  parameter int NIBBLES = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [PG_W-1:0]               prop_i,
  input  logic [PG_W-1:0]               gen_i,
  input  logic                          last_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum_o,
  output logic                          carry_o,
  output logic                          overflow_o,
  output logic                          len_err_o,
  output logic                          valid_o,
  input  logic                          ready_i
);
  localparam int SW = NIBBLE_W * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);
  post_state_t state;
  logic [CW-1:0] cnt;
  logic carry_q, c_in, first, accept, close;
  logic [NIBBLE_W:1] c;
  logic [NIBBLE_W-1:0] nib;
  assign first   = state == IDLE;
  assign c_in    = first ? gen_i[0] : carry_q;
  assign ready_o = rst_ni && state != HOLD;
  assign valid_o = state == HOLD;
  assign accept  = valid_i && ready_o;
  assign close   = last_i || (first ? (NIBBLES == 1) : (cnt == LAST_CNT));
  prefix_carry_4b u_carry (
    .prop  (prop_i),
    .gen   (gen_i),
    .c_in  (c_in),
    .carry (c),
    .sum   (nib)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      cnt        <= '0;
      carry_q    <= 1'b0;
      sum_o      <= '0;
      carry_o    <= 1'b0;
      overflow_o <= 1'b0;
      len_err_o  <= 1'b0;
    end else if (accept) begin
      carry_q <= c[NIBBLE_W];
      cnt     <= first ? CW'(1) : cnt + 1'b1;
      if (first) sum_o <= SW'(nib);
      else sum_o[NIBBLE_W*int'(cnt) +: NIBBLE_W] <= nib;
      state <= close ? HOLD : ACCUM;
      if (close) begin
        carry_o    <= c[NIBBLE_W];
        overflow_o <= c[NIBBLE_W] ^ c[NIBBLE_W-1];
        len_err_o  <= ~last_i;
      end
    end else if (state == HOLD && ready_i) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_post_processing_4b_seq.sv
// tb_post_processing_4b_seq: directed table, hand sequences and random ops against an arithmetic model
module tb_post_processing_4b_seq;
  logic clk = 0, rst_n = 0;
  logic [4:0] prop = '0, gen = '0;
  logic last = 0, valid = 0, rdy_in = 0, sel = 0;
  logic r2, v2, c2, o2, l2, r8, v8, c8, o8, l8;
  logic [7:0] s2;
  logic [31:0] s8;
  logic rdy, vld, cy, ov, le;
  logic [31:0] sm;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  post_processing_4b_seq #(.NIBBLES(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .prop_i(prop), .gen_i(gen), .last_i(last),
    .valid_i(valid & ~sel), .ready_o(r2), .sum_o(s2), .carry_o(c2),
    .overflow_o(o2), .len_err_o(l2), .valid_o(v2), .ready_i(rdy_in & ~sel));
  post_processing_4b_seq #(.NIBBLES(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .prop_i(prop), .gen_i(gen), .last_i(last),
    .valid_i(valid & sel), .ready_o(r8), .sum_o(s8), .carry_o(c8),
    .overflow_o(o8), .len_err_o(l8), .valid_o(v8), .ready_i(rdy_in & sel));

  assign rdy = sel ? r8 : r2;
  assign vld = sel ? v8 : v2;
  assign cy  = sel ? c8 : c2;
  assign ov  = sel ? o8 : o2;
  assign le  = sel ? l8 : l2;
  assign sm  = sel ? s8 : {24'b0, s2};

  typedef struct {
    logic sel; int m; logic [31:0] a, b; logic cin, last_end;
    logic [31:0] sum; logic carry, ovf, le;
  } vec_t;
  vec_t vt[6];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic send(input logic [4:0] p, input logic [4:0] g, input logic l);
    int k = 0;
    @(negedge clk);
    prop = p; gen = g; last = l; valid = 1;
    while (!rdy && k < 50) begin @(negedge clk); k++; end
    check("beat_ready", {31'b0, rdy}, 32'd1);
    @(posedge clk); #1 valid = 0; last = 0;
  endtask

  task automatic drive_op(input logic s, input int m, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic last_end, input logic rnd);
    logic [3:0] an, bn;
    logic g0;
    sel = s;
    for (int k = 0; k < m; k++) begin
      if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
      an = a[4*k +: 4]; bn = b[4*k +: 4];
      g0 = (k == 0 || !rnd) ? cin : 1'($urandom);
      send({an ^ bn, 1'b0}, {an & bn, g0}, k == m - 1 ? last_end : 1'b0);
      if (k < m - 1) check("accum_valid", {31'b0, vld}, 32'd0);
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] s, input logic c,
                              input logic o, input logic l);
    check({tag, "_valid"}, {31'b0, vld}, 32'd1);
    check({tag, "_ready"}, {31'b0, rdy}, 32'd0);
    check({tag, "_sum"}, sm, s);
    check({tag, "_carry"}, {31'b0, cy}, {31'b0, c});
    check({tag, "_ovf"}, {31'b0, ov}, {31'b0, o});
    check({tag, "_lenerr"}, {31'b0, le}, {31'b0, l});
  endtask

  task automatic take_result(input int hold);
    logic [31:0] s0;
    s0 = sm;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, vld}, 32'd1);
      check("bp_ready", {31'b0, rdy}, 32'd0);
      check("bp_sum", sm, s0);
    end
    @(negedge clk); rdy_in = 1;
    @(posedge clk); #1 rdy_in = 0;
    check("handoff_valid", {31'b0, vld}, 32'd0);
    check("handoff_ready", {31'b0, rdy}, 32'd1);
  endtask

  task automatic model(input int m, input int n, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic last_end,
                       output logic [31:0] s, output logic c, output logic o, output logic l);
    logic [63:0] mask, av, bv, t;
    int top;
    mask = (64'd1 << (4 * m)) - 1;
    av = {32'b0, a} & mask;
    bv = {32'b0, b} & mask;
    t = av + bv + {63'b0, cin};
    s = 32'(t & mask);
    c = t[4*m];
    top = 4 * m - 1;
    o = (av[top] == bv[top]) && (t[top] != av[top]);
    l = (m == n) && !last_end;
  endtask

  initial begin
    logic [31:0] es, ra, rb;
    logic ec, eo, el, rs, rc, rl;
    int rm, rn;
    vt[0] = '{1'b0, 2, 32'h7F, 32'h01, 1'b0, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0};
    vt[1] = '{1'b0, 2, 32'hFF, 32'h00, 1'b1, 1'b1, 32'h00, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1, 32'h5, 32'h2, 1'b0, 1'b1, 32'h7, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b0, 2, 32'h12, 32'h34, 1'b0, 1'b0, 32'h46, 1'b0, 1'b0, 1'b1};
    vt[4] = '{1'b1, 8, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1};
    vt[5] = '{1'b1, 3, 32'hFFF, 32'h001, 1'b0, 1'b1, 32'h000, 1'b1, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check("rst_ready", {31'b0, rdy}, 32'd0);
      check("rst_valid", {31'b0, vld}, 32'd0);
      check("rst_sum", sm, 32'd0);
      check("rst_flags", {29'b0, cy, ov, le}, 32'd0);
    end
    @(negedge clk); rst_n = 1;
    #1 check("post_rst_ready", {31'b0, rdy}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      drive_op(vt[i].sel, vt[i].m, vt[i].a, vt[i].b, vt[i].cin, vt[i].last_end, 1'b0);
      check_result($sformatf("vec%0d", i), vt[i].sum, vt[i].carry, vt[i].ovf, vt[i].le);
      take_result(i == 0 ? 5 : 0);
    end

    drive_op(1'b0, 2, 32'h12, 32'h34, 1'b0, 1'b0, 1'b0);
    check_result("limit", 32'h46, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    prop = {4'h3 ^ 4'h4, 1'b0}; gen = {4'h3 & 4'h4, 1'b0}; last = 1; valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("holdoff_valid", {31'b0, vld}, 32'd1);
      check("holdoff_ready", {31'b0, rdy}, 32'd0);
      check("holdoff_sum", sm, 32'h46);
    end
    rdy_in = 1;
    @(posedge clk); #1 rdy_in = 0;
    check("holdoff_idle_valid", {31'b0, vld}, 32'd0);
    check("holdoff_retain_sum", sm, 32'h46);
    @(posedge clk); #1 valid = 0; last = 0;
    check_result("third_beat", 32'h07, 1'b0, 1'b0, 1'b0);
    take_result(0);

    sel = 0;
    send({4'hF ^ 4'hF, 1'b0}, {4'hF & 4'hF, 1'b1}, 1'b0);
    @(negedge clk); rst_n = 0;
    #1;
    check("midrst_ready", {31'b0, rdy}, 32'd0);
    check("midrst_sum", sm, 32'd0);
    check("midrst_flags", {28'b0, vld, cy, ov, le}, 32'd0);
    @(negedge clk); rst_n = 1;
    drive_op(1'b0, 2, 32'h01, 32'h00, 1'b0, 1'b1, 1'b0);
    check_result("after_rst", 32'h01, 1'b0, 1'b0, 1'b0);
    take_result(0);

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom);
      rn = rs ? 8 : 2;
      rm = $urandom_range(1, rn);
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      rl = rm < rn ? 1'b1 : 1'($urandom);
      model(rm, rn, ra, rb, rc, rl, es, ec, eo, el);
      drive_op(rs, rm, ra, rb, rc, rl, 1'b1);
      check_result($sformatf("rnd%0d", i), es, ec, eo, el);
      take_result($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
